// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register.
// Holds the PC, fetches over a combinational-read req/ready instruction port,
// and keeps one returned instruction in a buffer when a stall arrives
// together with fetch data, so that instruction is not lost.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic               clk,
    input  logic               rst,              // asynchronous, active-low
    input  logic               hazard_detected,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               fetch_stall
);

    // FETCH: a request is out for the instruction at pc.
    // HOLD:  the instruction at pc already sits in hold_buf; no request.
    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]         state_q,       state_d;
    logic [ADDR_W-1:0]  pc_q,          pc_d;
    logic [INSTR_W-1:0] hold_buf_q,    hold_buf_d;
    logic [ADDR_W-1:0]  if_id_pc_q,    if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;

    logic [ADDR_W-1:0]  pc_next;

    // Sequential PC wraps naturally modulo 2^ADDR_W.
    assign pc_next = pc_q + PC_STEP;

    // Request only in FETCH and never while reset is asserted.
    assign imem_req    = rst && (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign fetch_stall = imem_req && !imem_ready;

    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

    // Next-state logic: branch redirect > hazard stall > normal flow.
    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned (no latch).
        state_d       = state_q;
        pc_d          = pc_q;
        hold_buf_d    = hold_buf_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        if (branch_taken) begin
            // Redirect wins over everything: flush IF/ID, drop any buffered word.
            pc_d          = branch_addr;
            if_id_pc_d    = '0;
            if_id_instr_d = '0;
            if_id_valid_d = 1'b0;
            hold_buf_d    = '0;
            state_d       = ST_FETCH;
        end else if (state_q == ST_FETCH) begin
            if (imem_ready) begin
                if (hazard_detected) begin
                    // ID is frozen: park the returned word and stop requesting.
                    hold_buf_d = imem_rdata;
                    state_d    = ST_HOLD;
                end else begin
                    if_id_pc_d    = pc_next;
                    if_id_instr_d = imem_rdata;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_next;
                end
            end else if (!hazard_detected) begin
                // Memory wait with ID free to advance: insert a bubble.
                if_id_valid_d = 1'b0;
            end
        end else begin
            if (!hazard_detected) begin
                // Stall released: deliver the parked word and resume fetching.
                if_id_pc_d    = pc_next;
                if_id_instr_d = hold_buf_q;
                if_id_valid_d = 1'b1;
                pc_d          = pc_next;
                state_d       = ST_FETCH;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            // NOTE: hold_buf is a single register, so it is cleared on reset like any other flop.
            hold_buf_q    <= '0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_buf_q    <= hold_buf_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized traffic, each
// cycle compared against a queue-based behavioural model of the fetch stage.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        hazard_detected;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_stall;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid),
        .fetch_stall     (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: program counter, what ID currently holds, and a
    // queue of at most one instruction fetched but not yet handed to ID.
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_id_valid;
    logic [31:0] m_buf[$];

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    // A request is out whenever nothing is parked and reset is released.
    function automatic logic m_req();
        return rst && (m_buf.size() == 0);
    endfunction

    task automatic model_reset();
        m_pc       = 32'h0;
        m_id_pc    = 32'h0;
        m_id_instr = 32'h0;
        m_id_valid = 1'b0;
        m_buf.delete();
    endtask

    task automatic model_clock(input logic haz, input logic br, input logic [31:0] ba,
                               input logic rdy, input logic [31:0] rdata);
        if (br) begin
            m_pc       = ba;
            m_id_pc    = 32'h0;
            m_id_instr = 32'h0;
            m_id_valid = 1'b0;
            m_buf.delete();
        end else if (m_buf.size() == 0) begin
            if (rdy && haz) begin
                m_buf.push_back(rdata);
            end else if (rdy) begin
                m_id_pc    = m_pc + 32'd4;
                m_id_instr = rdata;
                m_id_valid = 1'b1;
                m_pc       = m_pc + 32'd4;
            end else if (!haz) begin
                m_id_valid = 1'b0;
            end
        end else if (!haz) begin
            m_id_pc    = m_pc + 32'd4;
            m_id_instr = m_buf.pop_front();
            m_id_valid = 1'b1;
            m_pc       = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        check("imem_req",    {31'b0, imem_req},    {31'b0, m_req()});
        check("imem_addr",   imem_addr,            m_pc);
        check("fetch_stall", {31'b0, fetch_stall}, {31'b0, m_req() && !imem_ready});
    endtask

    task automatic check_id();
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_id_valid});
        check("if_id_pc",    if_id_pc,             m_id_pc);
        check("if_id_instr", if_id_instr,          m_id_instr);
    endtask

    // One clock cycle: drive at the falling edge, check combinational outputs,
    // advance model and DUT on the rising edge, check IF/ID at the next falling edge.
    task automatic step(input logic haz, input logic br, input logic [31:0] ba, input logic rdy);
        logic [31:0] rd;
        rd = rdy ? mem_word(m_pc) : $urandom;
        hazard_detected = haz;
        branch_taken    = br;
        branch_addr     = ba;
        imem_ready      = rdy;
        imem_rdata      = rd;
        #1;
        check_comb();
        @(posedge clk);
        model_clock(haz, br, ba, rdy && m_req(), rd);
        @(negedge clk);
        check_id();
    endtask

    initial begin
        logic [31:0] r;
        rst             = 1'b0;
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
        branch_addr     = 32'h0;
        imem_ready      = 1'b0;
        imem_rdata      = 32'h0;
        model_reset();

        // Reset state held across edges.
        repeat (2) @(negedge clk);
        check_comb();
        check_id();
        rst = 1'b1;

        // 1: streaming from RESET_PC, one instruction per cycle.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_pc4", if_id_pc, 32'd4);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_pc8", if_id_pc, 32'd8);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_pc12", if_id_pc, 32'd12);
        check("t1_instr", if_id_instr, mem_word(32'd8));

        // 2: hazard for 3 cycles with memory ready, then release.
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("t2_req_low", {31'b0, imem_req}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t2_no_skip", if_id_pc, 32'd16);
        check("t2_buf_instr", if_id_instr, mem_word(32'd12));
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t2_no_dup", if_id_pc, 32'd20);

        // 3: memory wait for 2 cycles, then resume.
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_pc_held", imem_addr, 32'd20);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t3_resume", if_id_pc, 32'd24);
        // Memory wait under hazard keeps the ID instruction valid.
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // 4: enter HOLD, then branch together with hazard.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h100, 1'b1);
        check("t4_flush", {31'b0, if_id_valid}, 32'h0);
        check("t4_target", imem_addr, 32'h100);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t4_first", if_id_pc, 32'h104);
        // Branch colliding with a ready fetch also wins.
        step(1'b0, 1'b1, 32'h200, 1'b1);

        // 5: wrap from the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t5_wrap_pc", if_id_pc, 32'h0);
        check("t5_wrap_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // 6: asynchronous reset mid-HOLD.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_comb();
        check_id();
        @(negedge clk);
        check_comb();
        check_id();
        rst = 1'b1;
        hazard_detected = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t6_restart", if_id_pc, 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic br;
            logic haz;
            logic rdy;
            r   = $urandom;
            br  = ($urandom_range(0, 15) == 0);
            haz = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | r;
            step(haz, br, {r[31:2], 2'b00}, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
